// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for the 5-stage core.
// Tracks producers in EX, MEM and WB. It registers the EX operand-mux
// selects one cycle ahead and flags the load-use stall.
// A producer that has just left WB (the "retired last cycle" slot) needs no
// storage of its own. When a consumer enters EX, that producer was in WB one
// cycle earlier, which is exactly when the select is computed, so it yields
// code 11 at no extra cost.

// Per-source select: the youngest qualified writer of rs wins.
module fwd_src_sel #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0]      rs,
  input  logic                       used,
  input  logic [2:0]                 wr_en,  // [0]=EX [1]=MEM [2]=WB, pre-qualified
  input  logic [2:0][REG_ADDR_W-1:0] wr_rd,
  output logic [1:0]                 sel
);
  // priority match, x0 and unused sources never forward
  always_comb begin
    sel = 2'b00;
    if (used && rs != '0) begin
      if (wr_en[0] && wr_rd[0] == rs)      sel = 2'b01;
      else if (wr_en[1] && wr_rd[1] == rs) sel = 2'b10;
      else if (wr_en[2] && wr_rd[2] == rs) sel = 2'b11;
    end
  end
endmodule

module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ext_stall,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  load_use_stall
);
  localparam int STAGES = 2;  // slot index 0=EX, 1=MEM, 2=WB

  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:0]                 wr_pipe;
  logic [STAGES:0][REG_ADDR_W-1:0] rd_pipe;
  logic                            ex_mem_read;
  logic [STAGES:0]                 wr_en;
  logic [1:0][REG_ADDR_W-1:0]      src_rs;
  logic [1:0]                      src_used;
  logic [1:0][1:0]                 sel_c;
  logic [1:0][1:0]                 sel_q;
  logic                            bubble;

  assign src_rs   = {id_rs2, id_rs1};
  assign src_used = {id_rs2_used, id_rs1_used};

  // a slot forwards only when it is live, writes, and does not target x0
  always_comb begin
    for (int i = 0; i <= STAGES; i++)
      wr_en[i] = vld_pipe[i] & wr_pipe[i] & (rd_pipe[i] != '0);
  end

  for (genvar i = 0; i < 2; i++) begin : g_src
    fwd_src_sel #(.REG_ADDR_W(REG_ADDR_W)) u_src (
      .rs    (src_rs[i]),
      .used  (src_used[i]),
      .wr_en (wr_en),
      .wr_rd (rd_pipe),
      .sel   (sel_c[i])
    );
  end

  // load in EX feeding the ID instruction; flush and freeze mask it
  assign load_use_stall = wr_en[0] & ex_mem_read & id_valid &
                          ((id_rs1_used & (id_rs1 == rd_pipe[0])) |
                           (id_rs2_used & (id_rs2 == rd_pipe[0]))) &
                          ~flush & ~ext_stall;

  assign bubble    = flush | load_use_stall;
  assign fwd_a_sel = sel_q[0];
  assign fwd_b_sel = sel_q[1];

  // slot shift and select register; freeze holds everything, a bubble zeroes EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe    <= '0;
      wr_pipe     <= '0;
      rd_pipe     <= '0;
      ex_mem_read <= 1'b0;
      sel_q       <= '0;
    end else if (!ext_stall) begin
      if (bubble) begin
        vld_pipe    <= {vld_pipe[STAGES-1:0], 1'b0};
        wr_pipe     <= {wr_pipe[STAGES-1:0], 1'b0};
        rd_pipe     <= {rd_pipe[STAGES-1:0], {REG_ADDR_W{1'b0}}};
        ex_mem_read <= 1'b0;
        sel_q       <= '0;
      end else begin
        vld_pipe    <= {vld_pipe[STAGES-1:0], id_valid};
        wr_pipe     <= {wr_pipe[STAGES-1:0], id_reg_write};
        rd_pipe     <= {rd_pipe[STAGES-1:0], id_rd};
        ex_mem_read <= id_mem_read;
        sel_q       <= id_valid ? sel_c : '0;
      end
    end
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench. The driver pushes the hand-computed expected
// {fwd_a_sel, fwd_b_sel, load_use_stall} for each cycle. The monitor pops
// and compares at the following falling edge.
module tb_fwd_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic       ext_stall = 1'b0, flush = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       load_use_stall;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       s;
    string      name;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;

  fwd_hazard_ctrl #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ext_stall(ext_stall), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      compared++;
      if (fwd_a_sel !== e.a || fwd_b_sel !== e.b || load_use_stall !== e.s) begin
        mismatched++;
        $display("FAIL %s: got a=%b b=%b stall=%b, want a=%b b=%b stall=%b",
                 e.name, fwd_a_sel, fwd_b_sel, load_use_stall, e.a, e.b, e.s);
      end
    end
  end

  // apply one cycle of ID-side inputs just after the edge and queue the expectation
  task automatic cyc(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic ext, input logic fl,
                     input logic r, input logic [1:0] ea, input logic [1:0] eb,
                     input logic es, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2;
    id_rs2_used = u2; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    ext_stall = ext; flush = fl;
    e.a = ea; e.b = eb; e.s = es; e.name = name;
    q.push_back(e);
  endtask

  task automatic nop(input logic ext, input logic r, input logic [1:0] ea,
                     input logic [1:0] eb, input logic es, input string name);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, ext, 0, r, ea, eb, es, name);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    nop(0, 0, 2'b00, 2'b00, 0, "reset_state");
    // distance 1: add x1 ; add x2,x1,x3
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "d1_prod");
    cyc(1, 1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "d1_cons_id");
    nop(0, 0, 2'b01, 2'b00, 0, "d1_sel");
    // distance 2: add x7 ; nop ; add x8,x7,x0
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "d2_prod");
    nop(0, 0, 2'b00, 2'b00, 0, "d2_gap");
    cyc(1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "d2_cons_id");
    nop(0, 0, 2'b10, 2'b00, 0, "d2_sel");
    // distance 3: add x9 ; nop ; nop ; add x10,x12,x9
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "d3_prod");
    nop(0, 0, 2'b00, 2'b00, 0, "d3_gap1");
    nop(0, 0, 2'b00, 2'b00, 0, "d3_gap2");
    cyc(1, 12, 1, 9, 1, 10, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "d3_cons_id");
    nop(0, 0, 2'b00, 2'b11, 0, "d3_sel");
    // distance 4: producer has left every slot
    cyc(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "d4_prod");
    nop(0, 0, 2'b00, 2'b00, 0, "d4_gap1");
    nop(0, 0, 2'b00, 2'b00, 0, "d4_gap2");
    nop(0, 0, 2'b00, 2'b00, 0, "d4_gap3");
    cyc(1, 13, 1, 0, 0, 14, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "d4_cons_id");
    nop(0, 0, 2'b00, 2'b00, 0, "d4_sel");
    // two producers of x5, youngest wins on both sources
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "x5_old");
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "x5_new");
    cyc(1, 5, 1, 5, 1, 11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "x5_cons_id");
    nop(0, 0, 2'b01, 2'b01, 0, "x5_sel");
    // lw x4 ; sub x6,x4,x4 -> one stall cycle, bubble, then 10/10
    cyc(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, "lu_load");
    cyc(1, 4, 1, 4, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, "lu_stall");
    cyc(1, 4, 1, 4, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "lu_bubble");
    nop(0, 0, 2'b10, 2'b10, 0, "lu_sel");
    // x0 writer, x0 reader, unused rs2 matching a live rd
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "x0_prod");
    cyc(1, 0, 0, 0, 0, 15, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "x15_prod");
    cyc(1, 0, 1, 15, 0, 16, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "x0_cons_id");
    nop(0, 0, 2'b00, 2'b00, 0, "x0_sel");
    // load-use masked by flush
    cyc(1, 0, 0, 0, 0, 20, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, "fl_load");
    cyc(1, 20, 1, 0, 0, 18, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, "fl_masked");
    cyc(1, 17, 1, 0, 0, 19, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "fl_bubble");
    nop(0, 0, 2'b00, 2'b00, 0, "fl_no_stale");
    // freeze while EX has sel 01; MEM must still hold x21 afterwards
    cyc(1, 0, 0, 0, 0, 21, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "es_prod");
    cyc(1, 21, 1, 0, 0, 23, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "es_cons_id");
    cyc(1, 0, 0, 21, 1, 22, 1, 0, 1, 0, 0, 2'b01, 2'b00, 0, "es_hold1");
    cyc(1, 0, 0, 21, 1, 22, 1, 0, 1, 0, 0, 2'b01, 2'b00, 0, "es_hold2");
    cyc(1, 0, 0, 21, 1, 22, 1, 0, 1, 0, 0, 2'b01, 2'b00, 0, "es_hold3");
    cyc(1, 0, 0, 21, 1, 22, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, "es_release");
    nop(0, 0, 2'b00, 2'b10, 0, "es_slots_kept");
    // reset in the middle of a load-use stall
    cyc(1, 0, 0, 0, 0, 24, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, "rs_load");
    cyc(1, 24, 1, 0, 0, 25, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, "rs_stall");
    cyc(1, 24, 1, 0, 0, 25, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, "rs_async");
    cyc(1, 24, 1, 0, 0, 25, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, "rs_after");
    nop(0, 0, 2'b00, 2'b00, 0, "rs_user_sel");
    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
